ram_bank_array: RTL and testbench
=================================

# ram_bank_array

Multi-bank, parametrised successor to the single-bank RAM: NUM_BANKS independent banks of MEM_HEIGHT × DATA_BIT words behind one write port and one read port. Read data is registered and qualified by a valid strobe. A built-in clear sequencer zero-fills every bank after reset or on request. Sits between datapath producers and consumers as the shared scratch store.

## Interface
- ADDR_BIT, 3, row address bits per bank; MEM_HEIGHT = 2**ADDR_BIT
- DATA_BIT, 16, word width
- NUM_BANKS, 2, bank count; power of two, ≥ 2
- BANK_BIT, $clog2(NUM_BANKS), derived; not to be overridden
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  global enable; gates both ports
- we  in  1  write strobe
- re  in  1  read strobe
- clr  in  1  one-cycle pulse, request re-clear of all banks
- addr_w  in  BANK_BIT+ADDR_BIT  write address; upper BANK_BIT bits = bank, lower = row
- d_w  in  DATA_BIT  write data
- addr_r  in  BANK_BIT+ADDR_BIT  read address, same mapping
- d_r  out  DATA_BIT  registered read data
- r_valid  out  1  d_r updated this cycle
- init_busy  out  1  clear sequencer active; ports ignored

## Operation
- FSM states: INIT, READY. rst sampled high → INIT, row counter cnt = 0.
- INIT: each cycle writes 0 to row cnt in every bank, cnt increments; at cnt == MEM_HEIGHT-1 → READY. init_busy = 1 throughout INIT.
- READY: clr sampled high → INIT, cnt = 0. clr during INIT restarts cnt at 0.
- Write accepted when state READY, en, we: mem[bank(addr_w)][row(addr_w)] <= d_w.
- Read accepted when state READY, en, re: d_r <= mem[bank(addr_r)][row(addr_r)], r_valid <= 1 next cycle.
- No accepted read: r_valid <= 0, d_r holds last value.
- we/re asserted during INIT: dropped silently, no stall, r_valid stays 0.
- Writes and reads to different banks, or same bank different rows, are independent and concurrent.
- Same-address read and write in one cycle: behaviour set by RAM_BANK_BYPASS_EN (see Configuration).
- clr and we on the same READY cycle: clr wins, write dropped.
- Reset values: d_r = 0, r_valid = 0, init_busy = 1; memory contents undefined until INIT completes.

## Timing
- Read latency 1: address at edge N → d_r, r_valid valid after edge N+1.
- Write visible to a read issued at the following edge.
- Clear: rst deasserted at edge N → init_busy falls after edge N+MEM_HEIGHT; first accepted access at that edge.
- rst mid-clear or mid-read: next edge forces INIT, cnt = 0, r_valid = 0, d_r = 0; pending read discarded.
- Back-to-back reads every cycle: r_valid continuously high, one word per cycle.

## Configuration
- RAM_BANK_BYPASS_EN defined: same-address read/write in one cycle returns new d_w on d_r (write-first forwarding).
- Undefined: returns prior stored word (read-first); no forwarding mux synthesised.

## Structure
- Package ram_bank_pkg: FSM state enum {INIT, READY}, address-split helper functions (bank/row extract), parameter-check constants.
- Sub-module ram_bank_core: one bank, storage array plus write port and synchronous read; instantiated NUM_BANKS times via generate. Top holds FSM, counter, bank decode, output mux, bypass.

## Test plan
- Reset 1 cycle, release → init_busy high exactly 8 cycles (defaults), then low; read all 16 addresses → all 0, r_valid high each following cycle.
- Write addr_w 0..15 with d_w = addr + 16'h100, then read 15..0 → d_r = 16'h10F..16'h100, one cycle after each address.
- Same cycle write addr 5 (bank 0) d_w 16'hAAAA and read addr 13 (bank 1) → d_r = stored bank-1 value, then read 5 → 16'hAAAA.
- Same-address write 16'h1234 over 16'h0042 with read → d_r = 16'h1234 with RAM_BANK_BYPASS_EN, 16'h0042 without.
- clr pulse after filling → init_busy 8 cycles, writes/reads during it dropped (r_valid 0), subsequent reads all 0.
- rst asserted mid-read stream → next cycle r_valid 0, d_r 0, init_busy 1; re-clear completes normally.

Source files
------------

// File: rtl/ram_bank_pkg.sv
// ram_bank_pkg: shared FSM states, address-split helpers and configuration limits for ram_bank_array
package ram_bank_pkg;
  typedef enum logic {INIT, READY} state_t;
  localparam int MIN_BANKS = 2;
  function automatic bit is_pow2(input int n);
    return n > 0 && (n & (n - 1)) == 0;
  endfunction
  function automatic int unsigned bank_of(input int unsigned addr, input int unsigned abits);
    return addr >> abits;
  endfunction
  function automatic int unsigned row_of(input int unsigned addr, input int unsigned abits);
    return addr & ((32'd1 << abits) - 32'd1);
  endfunction
endpackage

// File: rtl/ram_bank_core.sv
// ram_bank_core: one storage bank with a write port and a registered, read-first read port
module ram_bank_core #(
  parameter int ADDR_BIT = 3,
  parameter int DATA_BIT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDR_BIT-1:0] waddr,
  input  logic [DATA_BIT-1:0] wdata,
  input  logic                re,
  input  logic [ADDR_BIT-1:0] raddr,
  output logic [DATA_BIT-1:0] rdata
);
  logic [DATA_BIT-1:0] mem [2**ADDR_BIT];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/ram_bank_array.sv
// ram_bank_array: NUM_BANKS-bank RAM with clear sequencer; define RAM_BANK_BYPASS_EN for write-first same-address reads
module ram_bank_array
  import ram_bank_pkg::*;
#(
  parameter int ADDR_BIT  = 3,
  parameter int DATA_BIT  = 16,
  parameter int NUM_BANKS = 2,
  parameter int BANK_BIT  = $clog2(NUM_BANKS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         we,
  input  logic                         re,
  input  logic                         clr,
  input  logic [BANK_BIT+ADDR_BIT-1:0] addr_w,
  input  logic [DATA_BIT-1:0]          d_w,
  input  logic [BANK_BIT+ADDR_BIT-1:0] addr_r,
  output logic [DATA_BIT-1:0]          d_r,
  output logic                         r_valid,
  output logic                         init_busy
);
  if (NUM_BANKS < MIN_BANKS || !is_pow2(NUM_BANKS) || BANK_BIT != $clog2(NUM_BANKS)) begin : g_bad_cfg
    $error("ram_bank_array: NUM_BANKS must be a power of two >= 2 with BANK_BIT left derived");
  end
  state_t              state;
  logic [ADDR_BIT-1:0] cnt;
  logic                busy, wr_acc, rd_acc;
  logic [BANK_BIT-1:0] bank_w, bank_r, sel_q;
  logic [ADDR_BIT-1:0] row_w, row_r;
  logic [DATA_BIT-1:0] rdata [NUM_BANKS];
  assign bank_w    = BANK_BIT'(bank_of(32'(addr_w), ADDR_BIT));
  assign bank_r    = BANK_BIT'(bank_of(32'(addr_r), ADDR_BIT));
  assign row_w     = ADDR_BIT'(row_of(32'(addr_w), ADDR_BIT));
  assign row_r     = ADDR_BIT'(row_of(32'(addr_r), ADDR_BIT));
  assign busy      = state == INIT;
  assign init_busy = busy;
  // clr beats a same-cycle write so the clear never races fresh data
  assign wr_acc    = !busy && en && we && !clr;
  assign rd_acc    = !busy && en && re;
  always_ff @(posedge clk)
    if (rst) begin
      state   <= INIT;
      cnt     <= '0;
      r_valid <= 1'b0;
      sel_q   <= '0;
    end else begin
      r_valid <= rd_acc;
      if (rd_acc) sel_q <= bank_r;
      if (clr) begin
        state <= INIT;
        cnt   <= '0;
      end else if (busy) begin
        cnt <= cnt + 1'b1;
        if (cnt == '1) state <= READY;
      end
    end
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    ram_bank_core #(.ADDR_BIT(ADDR_BIT), .DATA_BIT(DATA_BIT)) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (busy || (wr_acc && bank_w == BANK_BIT'(b))),
      .waddr (busy ? cnt : row_w),
      .wdata (busy ? '0 : d_w),
      .re    (rd_acc && bank_r == BANK_BIT'(b)),
      .raddr (row_r),
      .rdata (rdata[b])
    );
  end
`ifdef RAM_BANK_BYPASS_EN
  logic                byp_q;
  logic [DATA_BIT-1:0] byp_d;
  always_ff @(posedge clk)
    if (rst) byp_q <= 1'b0;
    else if (rd_acc) begin
      byp_q <= wr_acc && addr_w == addr_r;
      byp_d <= d_w;
    end
  assign d_r = byp_q ? byp_d : rdata[sel_q];
`else
  assign d_r = rdata[sel_q];
`endif
endmodule

// File: tb/tb_ram_bank_array.sv
// tb_ram_bank_array: directed stimulus checked against a behavioural RAM model plus literal expectations
module tb_ram_bank_array;
`ifdef RAM_BANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 0, rst = 1, en = 0, we = 0, re = 0, clr = 0;
  logic [3:0] addr_w = 0, addr_r = 0;
  logic [15:0] d_w = 0, d_r;
  logic r_valid, init_busy;
  int total = 0, bad = 0;
  ram_bank_array dut (
    .clk(clk), .rst(rst), .en(en), .we(we), .re(re), .clr(clr),
    .addr_w(addr_w), .d_w(d_w), .addr_r(addr_r),
    .d_r(d_r), .r_valid(r_valid), .init_busy(init_busy)
  );
  always #5 clk = ~clk;
  logic [15:0] mem_m [16];
  bit busy_m, v_m, started;
  logic [15:0] d_m;
  int left;
  always @(posedge clk) begin
    if (rst) begin
      started = 1; busy_m = 1; left = 8; v_m = 0; d_m = 0;
    end else if (busy_m) begin
      v_m = 0;
      if (clr) left = 8;
      else begin
        left--;
        if (left == 0) begin
          busy_m = 0;
          foreach (mem_m[i]) mem_m[i] = 16'h0;
        end
      end
    end else begin
      v_m = en && re;
      if (v_m) d_m = (BYP && we && !clr && addr_w == addr_r) ? d_w : mem_m[addr_r];
      if (clr) begin busy_m = 1; left = 8; end
      else if (en && we) mem_m[addr_w] = d_w;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk)
    if (started) begin
      chk("model_busy", 32'(init_busy), 32'(busy_m));
      chk("model_valid", 32'(r_valid), 32'(v_m));
      chk("model_d_r", 32'(d_r), 32'(d_m));
    end
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic busy_len(input string nm);
    int n = 0;
    while (init_busy && n < 50) begin
      chk({nm, "_valid_low"}, 32'(r_valid), 0);
      n++;
      cyc();
    end
    chk(nm, n, 8);
  endtask
  initial begin
    cyc();
    chk("rst_busy", 32'(init_busy), 1);
    chk("rst_valid", 32'(r_valid), 0);
    chk("rst_d_r", 32'(d_r), 0);
    rst = 0;
    busy_len("init_len");
    en = 1; re = 1;
    for (int a = 0; a < 16; a++) begin
      addr_r = 4'(a); cyc();
      chk("init_zero", 32'(d_r), 0);
      chk("init_valid", 32'(r_valid), 1);
    end
    re = 0; we = 1;
    for (int a = 0; a < 16; a++) begin
      addr_w = 4'(a); d_w = 16'(a + 16'h100); cyc();
    end
    we = 0; re = 1;
    for (int k = 0; k < 16; k++) begin
      addr_r = 4'(15 - k); cyc();
      chk("rd_desc", 32'(d_r), 32'(16'h10F - k));
    end
    we = 1; addr_w = 5; d_w = 16'hAAAA; addr_r = 13; cyc();
    chk("cross_bank", 32'(d_r), 32'h10D);
    we = 0; addr_r = 5; cyc();
    chk("rd_after_wr", 32'(d_r), 32'hAAAA);
    re = 0; cyc();
    chk("hold_valid", 32'(r_valid), 0);
    chk("hold_d_r", 32'(d_r), 32'hAAAA);
    we = 1; addr_w = 2; d_w = 16'h0042; cyc();
    d_w = 16'h1234; re = 1; addr_r = 2; cyc();
    chk("same_addr", 32'(d_r), BYP ? 32'h1234 : 32'h0042);
    we = 0; cyc();
    chk("same_addr_after", 32'(d_r), 32'h1234);
    re = 0; clr = 1; we = 1; addr_w = 0; d_w = 16'hFFFF; cyc();
    clr = 0; re = 1; addr_w = 3; addr_r = 3; d_w = 16'h5555;
    busy_len("clr_len");
    we = 0;
    for (int a = 0; a < 16; a++) begin
      addr_r = 4'(a); cyc();
      chk("clr_zero", 32'(d_r), 0);
    end
    we = 1; re = 0; addr_w = 7; d_w = 16'h7777; cyc();
    we = 0; re = 1; addr_r = 7;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stream", 32'(d_r), 32'h7777);
    end
    rst = 1; cyc();
    chk("midrst_valid", 32'(r_valid), 0);
    chk("midrst_d_r", 32'(d_r), 0);
    chk("midrst_busy", 32'(init_busy), 1);
    rst = 0; re = 0;
    busy_len("reinit_len");
    re = 1; addr_r = 7; cyc();
    chk("reinit_zero", 32'(d_r), 0);
    re = 0; cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
